// File: rtl/neuron_event_rx_pkg.sv
// Shared definitions for the neuron event ingress path:
// event byte layout, type codes and the stored event record.
package neuron_event_rx_pkg;

  localparam int EV_VALID_BIT = 7;

  localparam logic [2:0] TYPE_SPIKE = 3'd1;
  localparam logic [2:0] TYPE_ACT   = 3'd2;
  localparam logic [2:0] TYPE_TICK  = 3'd3;
  localparam logic [2:0] TYPE_CFG   = 3'd4;

  typedef struct packed {
    logic [2:0] ev_type;
    logic [3:0] payload;
  } ev_t;

  function automatic logic ev_type_known(input logic [2:0] t);
    return (t == TYPE_SPIKE) || (t == TYPE_ACT) ||
           (t == TYPE_TICK)  || (t == TYPE_CFG);
  endfunction

  function automatic ev_t byte_to_ev(input logic [7:0] b);
    return ev_t'(b[6:0]);
  endfunction

endpackage

// File: rtl/neuron_event_rx_if.sv
// Upstream byte stream handshake.
// Master drives bytes, slave returns ready.
interface neuron_event_rx_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/neuron_event_rx_fifo.sv
// Synchronous event FIFO; full/empty come from
// an occupancy counter, pointers wrap naturally.
module neuron_event_rx_fifo
  import neuron_event_rx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  ev_t                    push_data_i,
  input  logic                   pop_i,
  output ev_t                    head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  ev_t           mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          push_ok, pop_ok;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A full FIFO never takes a push, even alongside a pop.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage write; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/neuron_event_rx.sv
// Neuron event ingress: classify bytes, buffer them,
// dispatch one registered event per cycle.
module neuron_event_rx
  import neuron_event_rx_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int TICK_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  neuron_event_rx_if.slave       in_if,
  input  logic                   core_busy,
  output logic                   active_event,
  output logic                   is_tick,
  output logic [2:0]             ev_type,
  output logic [3:0]             ev_payload,
  output logic                   cfg_valid,
  output logic [3:0]             cfg_payload,
  output logic [TICK_W-1:0]      tick_count,
  output logic [7:0]             err_count,
  output logic [$clog2(DEPTH):0] fifo_level
);

  ev_t  in_ev, head;
  logic full, empty;
  logic accept, ev_byte, known;
  logic push, err_hit, pop;
  logic head_cfg, head_tick;

  logic              act_q, act_d;
  logic              tick_q, tick_d;
  logic              cfg_q, cfg_d;
  logic [2:0]        type_q, type_d;
  logic [3:0]        pay_q, pay_d;
  logic [3:0]        cfgp_q, cfgp_d;
  logic [TICK_W-1:0] tcnt_q, tcnt_d;
  logic [7:0]        err_q, err_d;

  assign in_if.in_ready = !rst && !full;

  assign in_ev   = byte_to_ev(in_if.in_data);
  assign accept  = in_if.in_valid && in_if.in_ready;
  assign ev_byte = in_if.in_data[EV_VALID_BIT];
  assign known   = ev_type_known(in_ev.ev_type);
  assign push    = accept && ev_byte && known;
  assign err_hit = accept && ev_byte && !known;
  assign pop     = !empty && !core_busy && !rst;

  assign head_cfg  = (head.ev_type == TYPE_CFG);
  assign head_tick = (head.ev_type == TYPE_TICK);

  neuron_event_rx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (push),
    .push_data_i (in_ev),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (full),
    .empty_o     (empty),
    .level_o     (fifo_level)
  );

  // Route the popped head into pulses, fields and counters.
  always_comb begin
    act_d  = pop && !head_cfg;
    tick_d = pop && head_tick;
    cfg_d  = pop && head_cfg;
    type_d = type_q;
    pay_d  = pay_q;
    cfgp_d = cfgp_q;
    tcnt_d = tcnt_q;
    err_d  = err_q;
    if (act_d) begin
      type_d = head.ev_type;
      pay_d  = head.payload;
    end
    if (cfg_d)  cfgp_d = head.payload;
    if (tick_d) tcnt_d = tcnt_q + 1'b1;
    if (err_hit && err_q != 8'hFF) err_d = err_q + 1'b1;
  end

  // Output and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_q  <= 1'b0;
      tick_q <= 1'b0;
      cfg_q  <= 1'b0;
      type_q <= '0;
      pay_q  <= '0;
      cfgp_q <= '0;
      tcnt_q <= '0;
      err_q  <= '0;
    end else begin
      act_q  <= act_d;
      tick_q <= tick_d;
      cfg_q  <= cfg_d;
      type_q <= type_d;
      pay_q  <= pay_d;
      cfgp_q <= cfgp_d;
      tcnt_q <= tcnt_d;
      err_q  <= err_d;
    end
  end

  assign active_event = act_q;
  assign is_tick      = tick_q;
  assign cfg_valid    = cfg_q;
  assign ev_type      = type_q;
  assign ev_payload   = pay_q;
  assign cfg_payload  = cfgp_q;
  assign tick_count   = tcnt_q;
  assign err_count    = err_q;

endmodule

// File: tb/tb_neuron_event_rx.sv
// Bench for neuron_event_rx: queue-based reference
// model checked every cycle plus directed scenarios.
module tb_neuron_event_rx;
  import neuron_event_rx_pkg::*;

  localparam int DEPTH  = 4;
  localparam int TICK_W = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       core_busy = 1'b0;
  logic       active_event, is_tick, cfg_valid;
  logic [2:0] ev_type;
  logic [3:0] ev_payload, cfg_payload;
  logic [7:0] tick_count, err_count;
  logic [2:0] fifo_level;

  neuron_event_rx_if bus ();

  neuron_event_rx #(
    .DEPTH  (DEPTH),
    .TICK_W (TICK_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_if        (bus),
    .core_busy    (core_busy),
    .active_event (active_event),
    .is_tick      (is_tick),
    .ev_type      (ev_type),
    .ev_payload   (ev_payload),
    .cfg_valid    (cfg_valid),
    .cfg_payload  (cfg_payload),
    .tick_count   (tick_count),
    .err_count    (err_count),
    .fifo_level   (fifo_level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
  endtask

  // Reference model: plain queue of {type,payload}.
  logic [6:0] mq[$];
  logic [6:0] mh;
  logic       e_act, e_tick, e_cfg;
  logic [2:0] e_type;
  logic [3:0] e_pay, e_cfgp;
  logic [7:0] e_tcnt, e_err;
  bit         m_room, m_pop;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      {e_act, e_tick, e_cfg} = '0;
      e_type = '0; e_pay = '0; e_cfgp = '0;
      e_tcnt = '0; e_err = '0;
    end else begin
      m_room = mq.size() < DEPTH;
      m_pop  = mq.size() > 0 && !core_busy;
      {e_act, e_tick, e_cfg} = '0;
      if (m_pop) begin
        mh = mq.pop_front();
        if (mh[6:4] == 3'd4) begin
          e_cfg  = 1'b1;
          e_cfgp = mh[3:0];
        end else begin
          e_act  = 1'b1;
          e_type = mh[6:4];
          e_pay  = mh[3:0];
          if (mh[6:4] == 3'd3) begin
            e_tick = 1'b1;
            e_tcnt = e_tcnt + 8'd1;
          end
        end
      end
      if (bus.in_valid && m_room && bus.in_data[7]) begin
        if (bus.in_data[6:4] inside {[3'd1:3'd4]})
          mq.push_back(bus.in_data[6:0]);
        else if (e_err != 8'd255)
          e_err = e_err + 8'd1;
      end
    end
  end

  // Observed dispatches: {kind,2'b0,payload}, kind
  // 1=spike/act 2=tick 3=cfg 0=illegal both.
  logic [7:0] obs[$];
  int         obs_cyc[$];
  int         cyc = 0;
  logic [1:0] kind;

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    cyc++;
    check("in_ready", bus.in_ready,
          (!rst && mq.size() < DEPTH));
    check("fifo_level", fifo_level, mq.size());
    check("active_event", active_event, e_act);
    check("is_tick", is_tick, e_tick);
    check("cfg_valid", cfg_valid, e_cfg);
    check("cfg_payload", cfg_payload, e_cfgp);
    check("tick_count", tick_count, e_tcnt);
    check("err_count", err_count, e_err);
    if (e_act) begin
      check("ev_type", ev_type, e_type);
      check("ev_payload", ev_payload, e_pay);
    end
    if (active_event || cfg_valid) begin
      if (cfg_valid) kind = active_event ? 2'd0 : 2'd3;
      else kind = is_tick ? 2'd2 : 2'd1;
      obs.push_back({kind, 2'b00, ev_payload});
      if (cfg_valid) obs[obs.size()-1][3:0] = cfg_payload;
      obs_cyc.push_back(cyc);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one byte until accepted (bounded).
  task automatic send(input logic [7:0] b);
    bit done = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = bus.in_ready;
      step(1);
    end
    bus.in_valid = 1'b0;
    if (!done) check("send_timeout", 0, 1);
  endtask

  // Hold one byte value until n accepts (bounded).
  task automatic stream(input logic [7:0] b, input int n);
    int acc = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int i = 0; i < 4 * n + 20 && acc < n; i++) begin
      @(negedge clk);
      if (bus.in_ready) acc++;
      step(1);
    end
    bus.in_valid = 1'b0;
    check("stream_accepts", acc, n);
  endtask

  int mark;
  int p;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    step(2);
    @(negedge clk);
    check("reset_in_ready", bus.in_ready, 0);
    check("reset_level", fifo_level, 0);
    check("reset_active", active_event, 0);
    step(1);
    rst = 1'b0;
    step(1);

    // Single TICK: pulse exactly 2 cycles after accept.
    send(8'hB0);
    @(negedge clk);
    check("tick_early", active_event, 0);
    step(1);
    @(negedge clk);
    check("tick_active", active_event, 1);
    check("tick_is_tick", is_tick, 1);
    check("tick_count_1", tick_count, 1);
    step(3);

    // Burst of 6 SPIKEs while stalled.
    mark = obs.size();
    core_busy = 1'b1;
    p = 1;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h90 | 8'(p);
      @(negedge clk);
      if (bus.in_ready) p++;
      step(1);
    end
    check("burst_accepted", p - 1, 4);
    @(negedge clk);
    check("burst_level", fifo_level, 4);
    check("burst_ready", bus.in_ready, 0);
    step(1);
    core_busy = 1'b0;
    for (int i = 0; i < 20 && p <= 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h90 | 8'(p);
      @(negedge clk);
      if (bus.in_ready) p++;
      step(1);
    end
    bus.in_valid = 1'b0;
    step(8);
    check("burst_count", obs.size() - mark, 6);
    if (obs.size() - mark == 6) begin
      for (int i = 0; i < 6; i++)
        check("burst_order", obs[mark+i], 8'h40 | 8'(i + 1));
      for (int i = 1; i < 4; i++)
        check("burst_b2b", obs_cyc[mark+i] - obs_cyc[mark+i-1], 1);
    end

    // Mixed: filler, CFG A, ACT 3.
    mark = obs.size();
    send(8'h00);
    send(8'hCA);
    send(8'hA3);
    step(6);
    check("mixed_count", obs.size() - mark, 2);
    if (obs.size() - mark == 2) begin
      check("mixed_cfg", obs[mark], 8'hCA);
      check("mixed_act", obs[mark+1], 8'h43);
    end
    check("mixed_err", err_count, 0);

    // 300 reserved-type bytes.
    mark = obs.size();
    stream(8'hD0, 300);
    step(4);
    check("resv_nodispatch", obs.size() - mark, 0);
    check("resv_err_sat", err_count, 255);

    // Fresh reset, then 257 TICKs wrap the counter to 1.
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    check("rst_err_clr", err_count, 0);
    stream(8'hB5, 257);
    step(6);
    check("tick_wrap", tick_count, 1);

    // Reset with 3 queued entries.
    core_busy = 1'b1;
    send(8'h91);
    send(8'h92);
    send(8'h93);
    @(negedge clk);
    check("q3_level", fifo_level, 3);
    step(1);
    rst = 1'b1;
    core_busy = 1'b0;
    step(1);
    @(negedge clk);
    check("flush_level", fifo_level, 0);
    step(1);
    rst = 1'b0;
    mark = obs.size();
    step(6);
    check("flush_nopulse", obs.size() - mark, 0);
    check("flush_level2", fifo_level, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
